// File: rtl/led_sched_pkg.sv
// Shared types and round-robin helper for the LEDG bank scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLINK   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Only meaningful when req != 0; with both requesting, the one not served last wins.
  function automatic logic rr_winner(input logic [1:0] req, input logic last_served);
    if (req == 2'b11) return ~last_served;
    return req[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Phase timer: counts 0..TICK_DIV while enabled and flags the terminal count.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)     cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (enable)  cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the LEDG bank: latches the winner's pattern at grant and
// blinks PAT / ~PAT for N_BLINKS phases, then pulses DONE for one RELEASE cycle.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int N_BLINKS = 4,
  parameter int LED_W    = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [1:0]       REQ,
  input  logic [LED_W-1:0] PAT0,
  input  logic [LED_W-1:0] PAT1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  output logic             BUSY,
  output logic [LED_W-1:0] LEDG
);

  localparam int PH_W = (N_BLINKS > 1) ? $clog2(N_BLINKS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_BLINKS - 1);

  state_e          state;
  logic [PH_W-1:0] phase;
  logic            last_served;
  logic            grant;
  logic            win;
  logic            blink_en;
  logic            tick;

  assign grant    = (state == IDLE) && (REQ != 2'b00);
  assign win      = rr_winner(REQ, last_served);
  assign blink_en = (state == BLINK);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clear    (grant),
    .enable   (blink_en),
    .tick     (tick)
  );

  // last_served resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      phase       <= '0;
      last_served <= REQ1;
      GNT         <= '0;
      DONE        <= '0;
      BUSY        <= 1'b0;
      LEDG        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            GNT         <= win ? 2'b10 : 2'b01;
            LEDG        <= win ? PAT1 : PAT0;
            phase       <= '0;
            last_served <= win;
            BUSY        <= 1'b1;
            state       <= BLINK;
          end
        end
        BLINK: begin
          if (tick) begin
            if (phase == PH_LAST) begin
              LEDG              <= '0;
              GNT               <= '0;
              DONE[last_served] <= 1'b1;
              state             <= RELEASE;
            end else begin
              LEDG  <= ~LEDG;
              phase <= phase + 1'b1;
            end
          end
        end
        RELEASE: begin
          DONE  <= '0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed and randomized check of led_blink_scheduler against an elapsed-time model.
module tb_led_blink_scheduler;

  localparam int TD  = 10;
  localparam int NB  = 4;
  localparam int LW  = 2;
  localparam int PH  = TD + 1;
  localparam int SEQ = NB * PH;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req   = 2'b00;
  logic [LW-1:0] pat0  = '0;
  logic [LW-1:0] pat1  = '0;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic          busy;
  logic [LW-1:0] ledg;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  led_blink_scheduler #(
    .TICK_DIV (TD),
    .N_BLINKS (NB),
    .LED_W    (LW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .REQ      (req),
    .PAT0     (pat0),
    .PAT1     (pat1),
    .GNT      (gnt),
    .DONE     (done),
    .BUSY     (busy),
    .LEDG     (ledg)
  );

  always #5 clk = ~clk;

  // Model: a grant is a window of SEQ blink cycles, one release cycle, then idle.
  bit            m_busy = 1'b0;
  bit            m_win  = 1'b0;
  bit            m_last = 1'b1;
  int            m_el   = 0;
  logic [LW-1:0] m_pat  = '0;

  function automatic bit pick(input logic [1:0] r, input bit last);
    if (r == 2'b11) return !last;
    return r[1];
  endfunction

  function automatic logic [1:0] onehot(input bit w);
    return w ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_last <= 1'b1;
      m_el   <= 0;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        m_busy <= 1'b1;
        m_el   <= 0;
        m_win  <= pick(req, m_last);
        m_last <= pick(req, m_last);
        m_pat  <= pick(req, m_last) ? pat1 : pat0;
      end
    end else if (m_el == SEQ) begin
      m_busy <= 1'b0;
    end else begin
      m_el <= m_el + 1;
    end
  end

  logic [1:0]    e_gnt, e_done;
  logic          e_busy;
  logic [LW-1:0] e_led;

  always_comb begin
    e_gnt  = '0;
    e_done = '0;
    e_busy = m_busy;
    e_led  = '0;
    if (m_busy && m_el < SEQ) begin
      e_gnt = onehot(m_win);
      e_led = ((m_el / PH) % 2 == 1) ? ~m_pat : m_pat;
    end else if (m_busy) begin
      e_done = onehot(m_win);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt",  8'(gnt),  8'(e_gnt));
      chk("model_done", 8'(done), 8'(e_done));
      chk("model_busy", 8'(busy), 8'(e_busy));
      chk("model_ledg", 8'(ledg), 8'(e_led));
    end
  end

  initial begin
    // Reset held with both requesting
    rst_n = 1'b0; req = 2'b11; pat0 = 2'b01; pat1 = 2'b11;
    repeat (2) @(negedge clk);
    chk_en = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ledg", 8'(ledg), 8'h00);
      chk("rst_gnt",  8'(gnt),  8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
    end

    // Single request, then drop REQ and change PAT mid-sequence
    req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    req = 2'b01; pat0 = 2'b01;
    for (int i = 0; i <= 47; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("single_gnt0",  8'(gnt),  8'h01);
        chk("single_led0",  8'(ledg), 8'h01);
        chk("single_busy0", 8'(busy), 8'h01);
      end
      if (i == 5) begin req = 2'b00; pat0 = 2'b10; end
      if (i == 11) chk("single_led11", 8'(ledg), 8'h02);
      if (i == 22) chk("single_led22", 8'(ledg), 8'h01);
      if (i == 33) chk("single_led33", 8'(ledg), 8'h02);
      if (i == 44) begin
        chk("single_led44",  8'(ledg), 8'h00);
        chk("single_gnt44",  8'(gnt),  8'h00);
        chk("single_done44", 8'(done), 8'h01);
      end
      if (i == 45) begin
        chk("single_busy45", 8'(busy), 8'h00);
        chk("single_done45", 8'(done), 8'h00);
      end
      if (i == 47) chk("single_nogrant", 8'(gnt), 8'h00);
    end

    // Both requesting after reset: 0, then 1, then 0
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    req = 2'b11; pat0 = 2'b01; pat1 = 2'b11;
    rst_n = 1'b1;
    for (int i = 0; i <= 92; i++) begin
      @(negedge clk);
      if (i == 0)  chk("both_gnt0", 8'(gnt), 8'h01);
      if (i == 46) begin
        chk("both_gnt46", 8'(gnt),  8'h02);
        chk("both_led46", 8'(ledg), 8'h03);
      end
      if (i == 92) chk("both_gnt92", 8'(gnt), 8'h01);
    end

    // Asynchronous reset in the middle of a blink sequence
    repeat (19) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_ledg", 8'(ledg), 8'h00);
    chk("async_gnt",  8'(gnt),  8'h00);
    chk("async_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_regrant", 8'(gnt), 8'h01);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req  = 2'($urandom);
      if ($urandom_range(0, 7) == 0) pat0 = LW'($urandom);
      if ($urandom_range(0, 7) == 0) pat1 = LW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
